// File: rtl/bcd_pkg.sv
// Shared BCD digit type, decade limits and load clamp used by the counter and its digit cells.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  // Non-decimal nibbles (A-F) saturate to 9 so a stored digit is always valid BCD.
  function automatic bcd_t bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: clear > load > step, advances only when its carry/borrow-in is set.
// cout is combinational so a whole step ripples through all decades in one cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] q,
  output logic       cout
);

  bcd_t q_q, q_d;

  assign q    = q_q;
  assign cout = cin & (up ? (q_q == BCD_MAX) : (q_q == BCD_ZERO));

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = BCD_ZERO;
    end else if (ld) begin
      q_d = bcd_sat(ld_val);
    end else if (step && cin) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? BCD_ZERO : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= BCD_ZERO;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-decade BCD up/down counter with clear/load; step_o and ovf are registered 1-cycle pulses.
// Define BCD_PRESCALER_EN to step once every PRESC_DIV enabled cycles instead of every enabled cycle.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int PRESC_DIV = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [4*N_DIGITS-1:0] digitos,
  output logic                  ovf,
  output logic                  step_o
);

  logic              step_cond;
  logic              step_fire;
  logic [N_DIGITS:0] carry;
  logic              ovf_q, ovf_d;
  logic              step_q, step_d;

`ifdef BCD_PRESCALER_EN
  localparam int            PW        = $clog2(PRESC_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  // The prescaler freezes during a load so a load never shifts the step phase.
  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (!load && en) begin
      presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign step_cond = en & (presc_q == PRESC_MAX);
`else
  // Without a prescaler the divider is unused; an illegal divider setting simply blocks stepping.
  localparam bit PRESC_OK = (PRESC_DIV >= 2);

  assign step_cond = en & PRESC_OK;
`endif

  // A step coinciding with clear or load is dropped, not deferred.
  assign step_fire = step_cond & ~clr & ~load;
  assign carry[0]  = 1'b1;

  for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .ld     (load),
      .ld_val (load_val[4*i +: 4]),
      .step   (step_fire),
      .up     (up),
      .cin    (carry[i]),
      .q      (digitos[4*i +: 4]),
      .cout   (carry[i+1])
    );
  end

  assign step_d = step_fire;
  assign ovf_d  = step_fire & carry[N_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      ovf_q  <= ovf_d;
    end
  end

  assign step_o = step_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter (4 digits, divider 4); follows BCD_PRESCALER_EN if defined.
module tb_bcd_updown_counter;

`ifdef BCD_PRESCALER_EN
  localparam int P = 4;
`else
  localparam int P = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] digitos;
  logic        ovf;
  logic        step_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bcd_updown_counter #(.N_DIGITS(4), .PRESC_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .digitos  (digitos),
    .ovf      (ovf),
    .step_o   (step_o)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0000;
    tick(3);
    n_chk++; if (digitos !== 16'h0000) begin n_fail++; $display("FAIL reset_digitos: got %h want 0000", digitos); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_chk++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b want 0", step_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_count_up;
    logic exp_step;
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12 * P; k++) begin
      tick(1);
      exp_step = ((k % P) == 0);
      n_chk++; if (step_o !== exp_step) begin n_fail++; $display("FAIL up_step_cycle%0d: got %b want %b", k, step_o, exp_step); end
    end
    en = 1'b0;
    n_chk++; if (digitos !== 16'h0012) begin n_fail++; $display("FAIL up_12_steps: got %h want 0012", digitos); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL up_12_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_wrap_up;
    load = 1'b1; load_val = 16'h9998;
    tick(1);
    load = 1'b0;
    n_chk++; if (digitos !== 16'h9998) begin n_fail++; $display("FAIL load_9998: got %h want 9998", digitos); end
    en = 1'b1; up = 1'b1;
    tick(P);
    n_chk++; if (digitos !== 16'h9999) begin n_fail++; $display("FAIL up_to_9999: got %h want 9999", digitos); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_at_9999: got %b want 0", ovf); end
    tick(P);
    n_chk++; if (digitos !== 16'h0000) begin n_fail++; $display("FAIL wrap_to_0000: got %h want 0000", digitos); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_up_wrap: got %b want 1", ovf); end
    en = 1'b0;
    tick(1);
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle: got %b want 0", ovf); end
    n_chk++; if (digitos !== 16'h0000) begin n_fail++; $display("FAIL hold_0000: got %h want 0000", digitos); end
  endtask

  task automatic test_borrow_down;
    load = 1'b1; load_val = 16'h1000;
    tick(1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    tick(P);
    n_chk++; if (digitos !== 16'h0999) begin n_fail++; $display("FAIL down_1000: got %h want 0999", digitos); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL down_1000_ovf: got %b want 0", ovf); end
    en = 1'b0; load = 1'b1; load_val = 16'h0000;
    tick(1);
    load = 1'b0; en = 1'b1;
    tick(P);
    n_chk++; if (digitos !== 16'h9999) begin n_fail++; $display("FAIL down_wrap: got %h want 9999", digitos); end
    n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_down_wrap: got %b want 1", ovf); end
    n_chk++; if (step_o !== 1'b1) begin n_fail++; $display("FAIL step_down_wrap: got %b want 1", step_o); end
    en = 1'b0;
  endtask

  task automatic test_priority;
    logic exp_step;
    en = 1'b1; up = 1'b1;
    tick(P - 1);
    n_chk++; if (digitos !== 16'h9999) begin n_fail++; $display("FAIL pre_collision: got %h want 9999", digitos); end
    clr = 1'b1; load = 1'b1; load_val = 16'h1234;
    tick(1);
    n_chk++; if (digitos !== 16'h0000) begin n_fail++; $display("FAIL clr_wins: got %h want 0000", digitos); end
    n_chk++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL clr_step: got %b want 0", step_o); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", ovf); end
    clr = 1'b0; en = 1'b0; load_val = 16'h12AF;
    tick(1);
    load = 1'b0;
    n_chk++; if (digitos !== 16'h1299) begin n_fail++; $display("FAIL load_clamp: got %h want 1299", digitos); end
    en = 1'b1;
    for (int k = 1; k <= P; k++) begin
      tick(1);
      exp_step = (k == P);
      n_chk++; if (step_o !== exp_step) begin n_fail++; $display("FAIL post_clr_step%0d: got %b want %b", k, step_o, exp_step); end
    end
    n_chk++; if (digitos !== 16'h1300) begin n_fail++; $display("FAIL ripple_1300: got %h want 1300", digitos); end
  endtask

  task automatic test_async_reset;
    logic exp_step;
    en = 1'b0; load = 1'b1; load_val = 16'h0355;
    tick(1);
    load = 1'b0; en = 1'b1; up = 1'b1;
    tick(2 * P);
    n_chk++; if (digitos !== 16'h0357) begin n_fail++; $display("FAIL reach_0357: got %h want 0357", digitos); end
`ifdef BCD_PRESCALER_EN
    tick(1);
`endif
    en = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if (digitos !== 16'h0000) begin n_fail++; $display("FAIL async_digitos: got %h want 0000", digitos); end
    n_chk++; if (step_o !== 1'b0) begin n_fail++; $display("FAIL async_step: got %b want 0", step_o); end
    n_chk++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL async_ovf: got %b want 0", ovf); end
    tick(2);
    rst_n = 1'b1; en = 1'b1;
    for (int k = 1; k <= P; k++) begin
      tick(1);
      exp_step = (k == P);
      n_chk++; if (step_o !== exp_step) begin n_fail++; $display("FAIL restart_step%0d: got %b want %b", k, step_o, exp_step); end
    end
    n_chk++; if (digitos !== 16'h0001) begin n_fail++; $display("FAIL restart_0001: got %h want 0001", digitos); end
  endtask

  task automatic test_enable_hold;
    int  pre;
    logic exp_step;
    pre = P / 2;
    tick(pre);
    n_chk++; if (digitos !== 16'h0001) begin n_fail++; $display("FAIL mid_prescale: got %h want 0001", digitos); end
    en = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      n_chk++; if (digitos !== 16'h0001 || step_o !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %h/%b want 0001/0", k, digitos, step_o);
      end
    end
    en = 1'b1;
    for (int k = 1; k <= P - pre; k++) begin
      tick(1);
      exp_step = (k == P - pre);
      n_chk++; if (step_o !== exp_step) begin n_fail++; $display("FAIL resume_step%0d: got %b want %b", k, step_o, exp_step); end
    end
    n_chk++; if (digitos !== 16'h0002) begin n_fail++; $display("FAIL resume_0002: got %h want 0002", digitos); end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_borrow_down();
    test_priority();
    test_async_reset();
    test_enable_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
